// File: rtl/pipes.sv
// Shared types for the M-extension sequencer: op encoding, 64-bit datapath
// width, sign-extended MIN constants and op-class helpers.
package pipes;

    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        OP_MUL,
        OP_MULW,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU,
        OP_DIVW,
        OP_DIVUW,
        OP_REMW,
        OP_REMUW
    } muldiv_op_t;

    localparam logic [XLEN-1:0] I64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] I32_MIN = 64'hFFFF_FFFF_8000_0000;

    function automatic logic op_is_mul(muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULW);
    endfunction

    function automatic logic op_is_w(muldiv_op_t op);
        return (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
               (op == OP_REMW) || (op == OP_REMUW);
    endfunction

    // Signed divide/remainder flavours (multiply is sign-agnostic in the low half)
    function automatic logic op_is_signed(muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
    endfunction

    function automatic logic op_is_rem(muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Issue-side bundle of muldiv_ctrl: op offer, flush, stall and result pulse.
interface muldiv_ctrl_if;
    import pipes::*;

    logic                in_valid;
    muldiv_op_t          in_op;
    logic [XLEN-1:0]     in_a;
    logic [XLEN-1:0]     in_b;
    logic                in_ready;
    logic                flush;
    logic                busy;
    logic                out_valid;
    logic [XLEN-1:0]     out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, flush,
        input  in_ready, busy, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, flush,
        output in_ready, busy, out_valid, out_result
    );

endinterface

// File: rtl/muldiv_fixup.sv
// Combinational operand and result conditioning for muldiv_ctrl.
// Operand half: W extension, divider magnitudes, special-case detection.
// Result half: sign restore, special-case override, W sign-extension.
module muldiv_fixup
    import pipes::*;
(
    input  muldiv_op_t      op_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] ext_a_c,
    output logic [XLEN-1:0] abs_a_c,
    output logic [XLEN-1:0] abs_b_c,
    output logic            qneg_c,
    output logic            rneg_c,
    output logic            dz_c,
    output logic            ovf_c,
    output logic            mz_c,

    input  muldiv_op_t      op_res,
    input  logic [XLEN-1:0] prod,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dividend,
    input  logic            res_qneg,
    input  logic            res_rneg,
    input  logic            res_dz,
    input  logic            res_ovf,
    input  logic            res_mz,
    output logic [XLEN-1:0] result_c
);

    logic [XLEN-1:0] ext_b;
    logic            neg_a;
    logic            neg_b;
    logic            in_w;
    logic            in_sg;
    logic            in_mul;

    // Operand conditioning at accept
    always_comb begin
        in_w   = op_is_w(op_in);
        in_sg  = op_is_signed(op_in);
        in_mul = op_is_mul(op_in);
        ext_a_c = a_in;
        ext_b   = b_in;
        if (in_w) begin
            ext_a_c = in_sg ? {{32{a_in[31]}}, a_in[31:0]} : {32'h0, a_in[31:0]};
            ext_b   = in_sg ? {{32{b_in[31]}}, b_in[31:0]} : {32'h0, b_in[31:0]};
        end
        neg_a   = in_sg & ext_a_c[XLEN-1];
        neg_b   = in_sg & ext_b[XLEN-1];
        abs_a_c = neg_a ? (~ext_a_c + 64'd1) : ext_a_c;
        abs_b_c = neg_b ? (~ext_b + 64'd1) : ext_b;
        qneg_c  = neg_a ^ neg_b;
        rneg_c  = neg_a;
        dz_c    = !in_mul && (ext_b == 64'd0);
        ovf_c   = in_sg && (ext_b == {XLEN{1'b1}}) &&
                  (ext_a_c == (in_w ? I32_MIN : I64_MIN));
        if (in_w) begin
            mz_c = in_mul && ((a_in[31:0] == 32'd0) || (b_in[31:0] == 32'd0));
        end else begin
            mz_c = in_mul && ((a_in == 64'd0) || (b_in == 64'd0));
        end
    end

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] res;
    logic            res_w;
    logic            res_is_rem;

    // Result conditioning in FIX
    always_comb begin
        res_w      = op_is_w(op_res);
        res_is_rem = op_is_rem(op_res);
        q_fix = res_qneg ? (~quo + 64'd1) : quo;
        r_fix = res_rneg ? (~rem + 64'd1) : rem;
        if (op_is_mul(op_res)) begin
            res = prod;
        end else if (res_is_rem) begin
            res = r_fix;
        end else begin
            res = q_fix;
        end
        if (res_dz) begin
            res = res_is_rem ? dividend : {XLEN{1'b1}};
        end else if (res_ovf) begin
            res = res_is_rem ? 64'd0 : (res_w ? I32_MIN : I64_MIN);
        end else if (res_mz) begin
            res = 64'd0;
        end
        result_c = res_w ? {{32{res[31]}}, res[31:0]} : res;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the shared multicycle multiplier/divider.
// Optional macro MULDIV_FASTPATH_EN: divide-by-zero, overflow and multiply
// by zero bypass the units and go straight to FIX.
module muldiv_ctrl
    import pipes::*;
(
    input  logic            clk,
    input  logic            reset,
    muldiv_ctrl_if.slave    io,
    output logic            mul_valid,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_c,
    output logic            div_valid,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_q,
    input  logic [XLEN-1:0] div_r
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIX,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    muldiv_op_t      op_q, op_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            mz_q, mz_d;
    logic            mul_valid_q, mul_valid_d;
    logic            div_valid_q, div_valid_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d;
    logic [XLEN-1:0] mul_b_q, mul_b_d;
    logic [XLEN-1:0] div_a_q, div_a_d;
    logic [XLEN-1:0] div_b_q, div_b_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;

    logic [XLEN-1:0] ext_a_c, abs_a_c, abs_b_c, result_c;
    logic            qneg_c, rneg_c, dz_c, ovf_c, mz_c;
    logic            sel_done_c;
    logic            fast_c;

    muldiv_fixup u_fixup (
        .op_in    (io.in_op),
        .a_in     (io.in_a),
        .b_in     (io.in_b),
        .ext_a_c  (ext_a_c),
        .abs_a_c  (abs_a_c),
        .abs_b_c  (abs_b_c),
        .qneg_c   (qneg_c),
        .rneg_c   (rneg_c),
        .dz_c     (dz_c),
        .ovf_c    (ovf_c),
        .mz_c     (mz_c),
        .op_res   (op_q),
        .prod     (mul_c),
        .quo      (div_q),
        .rem      (div_r),
        .dividend (dvd_q),
        .res_qneg (qneg_q),
        .res_rneg (rneg_q),
        .res_dz   (dz_q),
        .res_ovf  (ovf_q),
        .res_mz   (mz_q),
        .result_c (result_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        dvd_d        = dvd_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        dz_d         = dz_q;
        ovf_d        = ovf_q;
        mz_d         = mz_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        out_result_d = out_result_q;
        mul_valid_d  = 1'b0;
        div_valid_d  = 1'b0;
        out_valid_d  = 1'b0;

        sel_done_c = op_is_mul(op_q) ? mul_done : div_done;
`ifdef MULDIV_FASTPATH_EN
        fast_c = dz_c | ovf_c | mz_c;
`else
        fast_c = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (io.in_valid && !io.flush) begin
                    op_d    = io.in_op;
                    dvd_d   = ext_a_c;
                    qneg_d  = qneg_c;
                    rneg_d  = rneg_c;
                    dz_d    = dz_c;
                    ovf_d   = ovf_c;
                    mz_d    = mz_c;
                    mul_a_d = io.in_a;
                    mul_b_d = io.in_b;
                    div_a_d = abs_a_c;
                    div_b_d = abs_b_c;
                    if (fast_c) begin
                        state_d = S_FIX;
                    end else begin
                        state_d     = S_LAUNCH;
                        mul_valid_d = op_is_mul(io.in_op);
                        div_valid_d = !op_is_mul(io.in_op);
                    end
                end
            end
            S_LAUNCH: state_d = io.flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (io.flush) begin
                    state_d = S_DRAIN;
                end else if (sel_done_c) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (io.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    out_valid_d  = 1'b1;
                    out_result_d = result_c;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_DRAIN: if (sel_done_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_MUL;
            dvd_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            mz_q         <= 1'b0;
            mul_valid_q  <= 1'b0;
            div_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            dvd_q        <= dvd_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            dz_q         <= dz_d;
            ovf_q        <= ovf_d;
            mz_q         <= mz_d;
            mul_valid_q  <= mul_valid_d;
            div_valid_q  <= div_valid_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign mul_valid     = mul_valid_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign div_valid     = div_valid_q;
    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign io.busy       = busy_q;
    assign io.in_ready   = in_ready_q;
    assign io.out_result = out_result_q;
    // A flush landing on the DONE cycle must kill the pulse in that same cycle
    assign io.out_valid  = out_valid_q & ~io.flush;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier/divider units.
module tb_muldiv_ctrl;
    import pipes::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    logic        mul_valid, mul_done, div_valid, div_done;
    logic [63:0] mul_a, mul_b, mul_c, div_a, div_b, div_q, div_r;

    muldiv_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .io        (bus),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_c     (mul_c),
        .div_valid (div_valid),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          at;
        string       name;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Multiplier model: done low while busy, product valid the cycle after done rises
    int          mcnt;
    logic        mpend;
    logic [63:0] ma_cap, mb_cap;
    always @(posedge clk) begin
        if (!reset) begin
            mcnt <= 0; mul_done <= 1'b1; mpend <= 1'b0; mul_c <= '0;
        end else begin
            mpend <= 1'b0;
            if (mpend) mul_c <= mul_a * mul_b;
            if (mul_valid) begin
                mcnt <= LAT; mul_done <= 1'b0; mul_c <= 64'hDEAD_BEEF_DEAD_BEEF;
                ma_cap <= mul_a; mb_cap <= mul_b;
            end else if (mcnt > 1) begin
                mcnt <= mcnt - 1;
            end else if (mcnt == 1) begin
                mcnt <= 0; mul_done <= 1'b1; mpend <= 1'b1;
            end
        end
    end

    // Divider model, same handshake
    int          dcnt;
    logic        dpend;
    logic [63:0] da_cap, db_cap;
    always @(posedge clk) begin
        if (!reset) begin
            dcnt <= 0; div_done <= 1'b1; dpend <= 1'b0; div_q <= '0; div_r <= '0;
        end else begin
            dpend <= 1'b0;
            if (dpend) begin
                div_q <= (div_b == 0) ? '1 : div_a / div_b;
                div_r <= (div_b == 0) ? div_a : div_a % div_b;
            end
            if (div_valid) begin
                dcnt <= LAT; div_done <= 1'b0;
                div_q <= 64'hBAD0_BAD0_BAD0_BAD0; div_r <= 64'hBAD1_BAD1_BAD1_BAD1;
                da_cap <= div_a; db_cap <= div_b;
            end else if (dcnt > 1) begin
                dcnt <= dcnt - 1;
            end else if (dcnt == 1) begin
                dcnt <= 0; div_done <= 1'b1; dpend <= 1'b1;
            end
        end
    end

    // Operands must hold from launch until the unit finishes
    always @(negedge clk) begin
        if (reset && mcnt == 1) begin
            chk("mul_b_stable", mul_b, mb_cap);
            chk("mul_a_stable", mul_a, ma_cap);
        end
        if (reset && dcnt == 1) begin
            chk("div_b_stable", div_b, db_cap);
            chk("div_a_stable", div_a, da_cap);
        end
    end

    // Monitor: every out_valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset && bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: cycle %0d result %h expected no pulse", cyc, bus.out_result);
            end else begin
                mon_e = sbq.pop_front();
                chk(mon_e.name, bus.out_result, mon_e.res);
                chk({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.at));
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s_ready_timeout: in_ready %b expected 1", name, bus.in_ready);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || bus.in_ready !== 1'b1) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL drain_timeout: pending %0d expected 0", sbq.size());
        end
    endtask

    // Issue one op; returns the accept cycle
    task automatic run(input string name, input muldiv_op_t op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input bit fast,
                       input bit expect_out, output int acc);
        exp_t e;
        bit   f;
`ifdef MULDIV_FASTPATH_EN
        f = fast;
`else
        f = 1'b0;
`endif
        wait_ready(name);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        acc = cyc;
        if (expect_out) begin
            e.res  = res;
            e.at   = cyc + (f ? 2 : LAT + 4);
            e.name = name;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_result"}, bus.out_result, 64'd0);
        chk({tag, "_mul_valid"}, 64'(mul_valid), 64'd0);
        chk({tag, "_div_valid"}, 64'(div_valid), 64'd0);
        chk({tag, "_mul_a"}, mul_a, 64'd0);
        chk({tag, "_mul_b"}, mul_b, 64'd0);
        chk({tag, "_div_a"}, div_a, 64'd0);
        chk({tag, "_div_b"}, div_b, 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bus.in_valid = 1'b0;
        bus.in_op    = OP_MUL;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        run("mul_3_m5",    OP_MUL,   64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b1, acc);
        run("div_m7_2",    OP_DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, acc);
        run("rem_m7_2",    OP_REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, acc);
        run("divu_7_2",    OP_DIVU,  64'd7, 64'd2, 64'd3, 1'b0, 1'b1, acc);
        run("divu_by0",    OP_DIVU,  64'd99, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, acc);
        run("remu_by0",    OP_REMU,  64'h1234, 64'd0, 64'h1234, 1'b1, 1'b1, acc);
        run("div_ovf",     OP_DIV,   I64_MIN, '1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, acc);
        run("rem_ovf",     OP_REM,   I64_MIN, '1, 64'd0, 1'b1, 1'b1, acc);
        run("mulw_wrap",   OP_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, acc);
        run("divw_ovf",    OP_DIVW,  64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1, acc);
        run("remw_m7_2",   OP_REMW,  64'h1234_5678_FFFF_FFF9, 64'hAAAA_AAAA_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, acc);
        run("divuw_big",   OP_DIVUW, 64'h0000_0001_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b1, acc);
        run("mul_zero",    OP_MUL,   64'd0, 64'd5, 64'd0, 1'b1, 1'b1, acc);
        run("mulw_lo0",    OP_MULW,  64'h1_0000_0000, 64'd5, 64'd0, 1'b1, 1'b1, acc);
        wait_drain();

        // Flush while waiting on the multiplier: drain, no result
        run("mul_flushed", OP_MUL, 64'd9, 64'd9, 64'd81, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
        chk("drain_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("drain_until_done", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("drain_exit", 64'(bus.in_ready), 64'd1);
        run("mul_6_7", OP_MUL, 64'd6, 64'd7, 64'd42, 1'b0, 1'b1, acc);
        wait_drain();

        // Reset while waiting: everything back to reset values next cycle
        run("mul_reset", OP_MUL, 64'd5, 64'd5, 64'd25, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_reset_state("midop_reset");
        reset = 1'b1;
        run("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 1'b0, 1'b1, acc);
        wait_drain();

        // Flush in DONE: pulse suppressed, back to IDLE
        run("div_flush_done", OP_DIV, 64'd20, 64'd4, 64'd5, 1'b0, 1'b0, acc);
        while (cyc < acc + LAT + 4) begin
            @(posedge clk); #1;
        end
        chk("done_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("done_flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("done_flush_idle", 64'(bus.in_ready), 64'd1);

        // Flush in IDLE blocks accept
        bus.in_valid = 1'b1;
        bus.in_op    = OP_DIVU;
        bus.in_a     = 64'd8;
        bus.in_b     = 64'd2;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("idle_flush_block", 64'(bus.busy), 64'd0);
        repeat (LAT + 6) @(posedge clk);
        #1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
